alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// A request is granted (round-robin on ties), its operands are latched and
// presented to the ALU, the ALU result is captured one cycle later, and the
// response is held until the consumer accepts it. A response handshake may
// accept the next request in the same cycle, giving one operation per two
// cycles. The opcode decode assumes OPW >= 5.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  input  logic [2*OPW-1:0]   req_op_i,
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  output logic [OPW-1:0]     alu_op_o,
  input  logic [WIDTH-1:0]   alu_c_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic [WIDTH-1:0]   rsp_result_o,
  output logic               rsp_branch_o,
  output logic               rsp_err_o,
  input  logic               flush_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Legal opcodes: 00,01,02,04-08,0D-0F,11,13,14,16,1F; any set bit above
  // bit 4 makes the opcode illegal.
  function automatic logic op_legal(input logic [OPW-1:0] op);
    logic [31:0] ext;
    ext = 32'(op);
    op_legal = 1'b0;
    if (ext[31:5] == 27'd0) begin
      case (ext[4:0])
        5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
        5'h0D, 5'h0E, 5'h0F, 5'h11, 5'h13, 5'h14, 5'h16, 5'h1F:
          op_legal = 1'b1;
        default: op_legal = 1'b0;
      endcase
    end
  endfunction

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [OPW-1:0]     op_q, op_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               branch_q, branch_d;
  logic               err_q, err_d;

  logic               grant_id;
  logic               accept_slot;
  logic               accept;
  logic               capture_legal;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid_i)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
  end

  // A new request can transfer in IDLE or in a RESP cycle whose response is
  // being taken; never during flush or while reset is held.
  assign accept_slot = !rst_i && !flush_i &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
  assign accept      = accept_slot && (req_valid_i != 2'b00);
  assign req_ready_o = accept ? (2'b01 << grant_id) : 2'b00;

  // The ALU always sees the latched operands so its inputs never glitch.
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_op_o     = op_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;
  assign rsp_branch_o = branch_q;
  assign rsp_err_o    = err_q;
  assign capture_legal = op_legal(op_q);

  // Next-state, operand latch and result capture.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    result_d     = result_q;
    branch_d     = branch_q;
    err_d        = err_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = EXEC;
        end
        EXEC: begin
          err_d    = !capture_legal;
          result_d = capture_legal ? alu_c_i : '0;
          branch_d = capture_legal && (op_q[4:3] == 2'b10) &&
                     (alu_c_i == WIDTH'(1));
          state_d  = RESP;
        end
        RESP: begin
          if (rsp_ready_i) state_d = accept ? EXEC : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      a_d          = grant_id ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
      b_d          = grant_id ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
      op_d         = grant_id ? req_op_i[2*OPW-1:OPW]    : req_op_i[OPW-1:0];
      id_d         = grant_id;
      last_grant_d = grant_id;
    end
  end

  // State and datapath registers; reset clears everything, last_grant to 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      branch_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      result_q     <= result_d;
      branch_q     <= branch_d;
      err_q        <= err_d;
    end
  end

endmodule
